// File: rtl/progmem_arbiter.sv
// rtl/progmem_arbiter.sv - N-core arbiter in front of a shared single-ported program memory
`ifndef INST_ADDR_W
`define INST_ADDR_W 16
`endif
`ifndef INST_W
`define INST_W 32
`endif

module progmem_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = `INST_ADDR_W,
    parameter int INST_W  = `INST_W,
    parameter int MEM_LAT = 1,
    parameter int RR      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [N_CORES-1:0]          core_req,
    input  logic [N_CORES*ADDR_W-1:0]   core_addr,
    output logic [N_CORES-1:0]          core_gnt,
    output logic [N_CORES-1:0]          core_valid,
    output logic [INST_W-1:0]           core_data,
    output logic                        mem_rd,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [INST_W-1:0]           mem_data
);
    localparam int PTR_W = $clog2(N_CORES);

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic               found;
    logic [N_CORES-1:0] tag [MEM_LAT];
    int                 idx;

    // Walk cores starting at ptr (RR) or at 0 (fixed); first requester wins.
    always_comb begin
        core_gnt = '0;
        mem_addr = '0;
        found    = 1'b0;
        ptr_next = ptr;
        idx      = 0;
        if (en && !rst && (|core_req)) begin
            for (int j = 0; j < N_CORES; j++) begin
                idx = (RR != 0) ? ((int'(ptr) + j) % N_CORES) : j;
                if (!found && core_req[idx]) begin
                    found         = 1'b1;
                    core_gnt[idx] = 1'b1;
                    mem_addr      = core_addr[idx*ADDR_W +: ADDR_W];
                    ptr_next      = PTR_W'((idx + 1) % N_CORES);
                end
            end
        end
    end

    assign mem_rd = found;

    // Tags drain regardless of en so every issued read returns to its owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            core_valid <= '0;
            core_data  <= '0;
            for (int i = 0; i < MEM_LAT; i++) tag[i] <= '0;
        end else begin
            tag[0] <= core_gnt;
            for (int i = 1; i < MEM_LAT; i++) tag[i] <= tag[i-1];
            core_valid <= tag[MEM_LAT-1];
            if (|tag[MEM_LAT-1]) core_data <= mem_data;
            if (found) ptr <= ptr_next;
        end
    end
endmodule

// File: tb/tb_progmem_arbiter.sv
// tb/tb_progmem_arbiter.sv - scoreboard bench for progmem_arbiter (RR/LAT1, fixed/LAT1, RR/LAT3)
module tb_progmem_arbiter;
    typedef struct {
        logic [3:0]  v;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_s   [3];
    logic        en_s    [3];
    logic [3:0]  req_s   [3];
    logic [31:0] addr_s  [3];
    logic [3:0]  gnt     [3];
    logic [3:0]  vld     [3];
    logic [31:0] cdata   [3];
    logic        rd      [3];
    logic [7:0]  maddr   [3];
    logic [31:0] mdata   [3];
    logic [31:0] pipe    [3][3];

    exp_t sb [3][$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;
    bit   armed = 0;

    progmem_arbiter #(.N_CORES(4), .ADDR_W(8), .INST_W(32), .MEM_LAT(1), .RR(1)) dut_rr (
        .clk(clk), .rst(rst_s[0]), .en(en_s[0]), .core_req(req_s[0]), .core_addr(addr_s[0]),
        .core_gnt(gnt[0]), .core_valid(vld[0]), .core_data(cdata[0]),
        .mem_rd(rd[0]), .mem_addr(maddr[0]), .mem_data(mdata[0]));

    progmem_arbiter #(.N_CORES(4), .ADDR_W(8), .INST_W(32), .MEM_LAT(1), .RR(0)) dut_fp (
        .clk(clk), .rst(rst_s[1]), .en(en_s[1]), .core_req(req_s[1]), .core_addr(addr_s[1]),
        .core_gnt(gnt[1]), .core_valid(vld[1]), .core_data(cdata[1]),
        .mem_rd(rd[1]), .mem_addr(maddr[1]), .mem_data(mdata[1]));

    progmem_arbiter #(.N_CORES(4), .ADDR_W(8), .INST_W(32), .MEM_LAT(3), .RR(1)) dut_l3 (
        .clk(clk), .rst(rst_s[2]), .en(en_s[2]), .core_req(req_s[2]), .core_addr(addr_s[2]),
        .core_gnt(gnt[2]), .core_valid(vld[2]), .core_data(cdata[2]),
        .mem_rd(rd[2]), .mem_addr(maddr[2]), .mem_data(mdata[2]));

    function automatic logic [31:0] memf(input logic [7:0] a);
        return {8'hA5, a, ~a, 8'h3C};
    endfunction

    function automatic int lat(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Memory model: data for a read issued in cycle t appears LAT cycles later.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            pipe[d][0] <= rd[d] ? memf(maddr[d]) : 32'hDEADBEEF;
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end
    end
    assign mdata[0] = pipe[0][0];
    assign mdata[1] = pipe[1][0];
    assign mdata[2] = pipe[2][2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Monitor: every return strobe must match the oldest expected entry, on its due cycle.
    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 3; d++) begin
                while (sb[d].size() > 0 && sb[d][0].due < cyc_n) begin
                    chk($sformatf("missed_valid_dut%0d", d), 64'(sb[d][0].due), 64'(cyc_n));
                    void'(sb[d].pop_front());
                end
                if (vld[d] !== 4'b0000) begin
                    if (sb[d].size() == 0) begin
                        chk($sformatf("unexpected_valid_dut%0d", d), 64'(vld[d]), 64'h0);
                    end else begin
                        exp_t e;
                        e = sb[d].pop_front();
                        chk($sformatf("valid_dut%0d", d), 64'(vld[d]), 64'(e.v));
                        chk($sformatf("data_dut%0d", d), 64'(cdata[d]), 64'(e.data));
                        chk($sformatf("latency_dut%0d", d), 64'(cyc_n), 64'(e.due));
                    end
                end
            end
        end
    end

    task automatic step(input int d, input bit r, input bit e, input logic [3:0] rq,
                        input logic [3:0] eg);
        logic [7:0] ea;
        exp_t       x;
        rst_s[d] = r;
        en_s[d]  = e;
        req_s[d] = rq;
        @(negedge clk);
        chk($sformatf("gnt_dut%0d", d), 64'(gnt[d]), 64'(eg));
        chk($sformatf("mem_rd_dut%0d", d), 64'(rd[d]), 64'(|eg));
        ea = 8'h00;
        for (int i = 0; i < 4; i++) if (eg[i]) ea = addr_s[d][i*8 +: 8];
        chk($sformatf("mem_addr_dut%0d", d), 64'(maddr[d]), 64'(ea));
        if (eg != 4'b0000 && !r) begin
            x.v    = eg;
            x.data = memf(ea);
            x.due  = cyc_n + lat(d) + 1;
            sb[d].push_back(x);
        end
        @(posedge clk);
        if (r) sb[d].delete();
        #1;
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) step(d, 1'b0, 1'b1, 4'b0000, 4'b0000);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_s[d]  = 1'b1;
            en_s[d]   = 1'b1;
            req_s[d]  = 4'b0000;
            addr_s[d] = 32'h13121110;
        end
        @(posedge clk);
        #1;

        // Reset with all cores requesting
        step(0, 1'b1, 1'b1, 4'b1111, 4'b0000);
        step(0, 1'b1, 1'b1, 4'b1111, 4'b0000);
        chk("reset_core_valid", 64'(vld[0]), 64'h0);
        chk("reset_core_data", 64'(cdata[0]), 64'h0);
        armed = 1'b1;

        // Round-robin rotation
        step(0, 1'b0, 1'b1, 4'b1111, 4'b0001);
        step(0, 1'b0, 1'b1, 4'b1111, 4'b0010);
        step(0, 1'b0, 1'b1, 4'b1111, 4'b0100);
        step(0, 1'b0, 1'b1, 4'b1111, 4'b1000);
        step(0, 1'b0, 1'b1, 4'b1111, 4'b0001);
        step(0, 1'b0, 1'b1, 4'b1111, 4'b0010);
        step(0, 1'b0, 1'b1, 4'b1111, 4'b0100);
        step(0, 1'b0, 1'b1, 4'b1111, 4'b1000);
        idle(0, 3);

        // Wrap and skip from ptr=3
        step(0, 1'b0, 1'b1, 4'b0100, 4'b0100);
        step(0, 1'b0, 1'b1, 4'b0101, 4'b0001);
        step(0, 1'b0, 1'b1, 4'b0101, 4'b0100);
        step(0, 1'b0, 1'b1, 4'b0101, 4'b0001);

        // All requesting with ptr=3
        step(0, 1'b0, 1'b1, 4'b0100, 4'b0100);
        step(0, 1'b0, 1'b1, 4'b1111, 4'b1000);
        step(0, 1'b0, 1'b1, 4'b1111, 4'b0001);
        step(0, 1'b0, 1'b1, 4'b1111, 4'b0010);

        // Single requester every cycle, then enable low
        step(0, 1'b0, 1'b1, 4'b1000, 4'b1000);
        step(0, 1'b0, 1'b1, 4'b1000, 4'b1000);
        step(0, 1'b0, 1'b1, 4'b1000, 4'b1000);
        step(0, 1'b0, 1'b0, 4'b1111, 4'b0000);
        step(0, 1'b0, 1'b0, 4'b1111, 4'b0000);
        step(0, 1'b0, 1'b1, 4'b1111, 4'b0001);
        idle(0, 3);

        // Fixed priority
        step(1, 1'b1, 1'b1, 4'b0000, 4'b0000);
        step(1, 1'b0, 1'b1, 4'b1110, 4'b0010);
        step(1, 1'b0, 1'b1, 4'b1110, 4'b0010);
        step(1, 1'b0, 1'b1, 4'b1110, 4'b0010);
        step(1, 1'b0, 1'b1, 4'b1100, 4'b0100);
        step(1, 1'b0, 1'b1, 4'b1100, 4'b0100);
        step(1, 1'b0, 1'b1, 4'b1111, 4'b0001);
        idle(1, 3);

        // LAT=3: enable stall with drain, ptr held across stall
        step(2, 1'b1, 1'b1, 4'b0000, 4'b0000);
        step(2, 1'b0, 1'b1, 4'b0100, 4'b0100);
        step(2, 1'b0, 1'b0, 4'b1111, 4'b0000);
        step(2, 1'b0, 1'b0, 4'b1111, 4'b0000);
        step(2, 1'b0, 1'b0, 4'b1111, 4'b0000);
        step(2, 1'b0, 1'b0, 4'b1111, 4'b0000);
        step(2, 1'b0, 1'b1, 4'b1111, 4'b1000);
        step(2, 1'b0, 1'b1, 4'b1111, 4'b0001);
        idle(2, 5);

        // LAT=3: reset with two reads in flight
        step(2, 1'b0, 1'b1, 4'b0001, 4'b0001);
        step(2, 1'b0, 1'b1, 4'b0010, 4'b0010);
        step(2, 1'b1, 1'b1, 4'b0000, 4'b0000);
        step(2, 1'b0, 1'b1, 4'b1111, 4'b0001);
        idle(2, 6);

        for (int d = 0; d < 3; d++)
            chk($sformatf("pending_dut%0d", d), 64'(sb[d].size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
